// File: rtl/msp_pkg.sv
// Shared definitions for the MSP430-style fetch and decode path.
// Opcode field constants and the source-extension rule live here.
package msp_pkg;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_CAPTURE,
    ST_HOLD
  } fetch_state_t;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [5:0] OP_FMT2 = 6'b000100;
  localparam logic [1:0] AS_IDX  = 2'b01;
  localparam logic [1:0] AS_IMM  = 2'b11;
  localparam logic [3:0] REG_PC  = 4'd0;
  localparam logic [3:0] REG_CG  = 4'd3;

  // Indexed mode needs a word unless r3 makes it a constant;
  // @PC+ is an immediate and needs one too.
  function automatic logic src_ext(
    input logic [1:0] as_f,
    input logic [3:0] rs
  );
    return ((as_f == AS_IDX) && (rs != REG_CG)) ||
           ((as_f == AS_IMM) && (rs == REG_PC));
  endfunction

endpackage

// File: rtl/msp_len_decode.sv
// Instruction length from the opcode word alone.
// Shared between fetch and the decoder.
module msp_len_decode
  import msp_pkg::*;
(
  input  logic [15:0] w,
  output logic [1:0]  len
);

  always_comb begin
    len = 2'd1;
    unique case (1'b1)
      (w[15:13] == OP_JMP):
        len = 2'd1;
      (w[15:10] == OP_FMT2):
        len = 2'd1 + {1'b0, src_ext(w[5:4], w[3:0])};
      (w[15:12] >= 4'd4):
        len = 2'd1 + {1'b0, src_ext(w[5:4], w[11:8])}
                   + {1'b0, w[7]};
      default:
        len = 2'd1;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding read, gathers up to three
// words and hands the whole instruction to decode via valid/ready.
module instr_fetch
  import msp_pkg::*;
#(
  parameter int          MEM_LAT  = 2,
  parameter logic [15:0] RESET_PC = 16'h0002
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] PC_ADDR,
  output logic        PC_ENA,
  input  logic [15:0] MEM_DATA,
  input  logic        BR_VALID,
  input  logic [15:0] BR_TARGET,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [15:0] INSTR_WORD,
  output logic [15:0] INSTR_EXT1,
  output logic [15:0] INSTR_EXT2,
  output logic [1:0]  INSTR_LEN,
  output logic [15:0] INSTR_PC
);

  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

  fetch_state_t state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  widx_q, widx_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic        ena_q, ena_d;
  logic        valid_q, valid_d;
  logic [15:0] word_q, word_d;
  logic [15:0] ext1_q, ext1_d;
  logic [15:0] ext2_q, ext2_d;
  logic [1:0]  len_q, len_d;
  logic [15:0] ipc_q, ipc_d;
  logic [1:0]  dec_len;
  logic [1:0]  cur_len;
  logic [15:0] br_pc;

  msp_len_decode u_len (
    .w   (MEM_DATA),
    .len (dec_len)
  );

  assign br_pc = BR_TARGET & 16'hFFFE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ena_d   = ena_q;
    valid_d = valid_q;
    word_d  = word_q;
    ext1_d  = ext1_q;
    ext2_d  = ext2_q;
    len_d   = len_q;
    ipc_d   = ipc_q;
    cur_len = (widx_q == 2'd0) ? dec_len : len_q;
    unique case (state_q)
      // REQ with the enable still low only happens right after reset
      ST_REQ: begin
        if (!ena_q) begin
          ena_d  = 1'b1;
          addr_d = pc_q;
        end else begin
          cnt_d   = 2'd1;
          state_d = (MEM_LAT == 1) ? ST_CAPTURE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q >= LAST_CNT) state_d = ST_CAPTURE;
        else cnt_d = cnt_q + 2'd1;
      end
      ST_CAPTURE: begin
        pc_d = pc_q + 16'd2;
        unique case (widx_q)
          2'd0: begin
            word_d = MEM_DATA;
            ext1_d = 16'h0000;
            ext2_d = 16'h0000;
            len_d  = dec_len;
            ipc_d  = pc_q;
          end
          2'd1:    ext1_d = MEM_DATA;
          default: ext2_d = MEM_DATA;
        endcase
        if ((widx_q + 2'd1) == cur_len) begin
          state_d = ST_HOLD;
          ena_d   = 1'b0;
          valid_d = 1'b1;
          widx_d  = 2'd0;
        end else begin
          state_d = ST_REQ;
          addr_d  = pc_q + 16'd2;
          widx_d  = widx_q + 2'd1;
        end
      end
      ST_HOLD: begin
        if (INSTR_READY) begin
          valid_d = 1'b0;
          state_d = ST_REQ;
          ena_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      default: ;
    endcase
    if (BR_VALID) begin
      state_d = ST_REQ;
      pc_d    = br_pc;
      addr_d  = br_pc;
      ena_d   = 1'b1;
      valid_d = 1'b0;
      widx_d  = 2'd0;
      cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_REQ;
      cnt_q   <= 2'd0;
      widx_q  <= 2'd0;
      pc_q    <= RESET_PC & 16'hFFFE;
      addr_q  <= 16'h0000;
      ena_q   <= 1'b0;
      valid_q <= 1'b0;
      word_q  <= 16'h0000;
      ext1_q  <= 16'h0000;
      ext2_q  <= 16'h0000;
      len_q   <= 2'd0;
      ipc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ena_q   <= ena_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      ext1_q  <= ext1_d;
      ext2_q  <= ext2_d;
      len_q   <= len_d;
      ipc_q   <= ipc_d;
    end
  end

  assign PC_ADDR     = addr_q;
  assign PC_ENA      = ena_q;
  assign INSTR_VALID = valid_q;
  assign INSTR_WORD  = word_q;
  assign INSTR_EXT1  = ext1_q;
  assign INSTR_EXT2  = ext2_q;
  assign INSTR_LEN   = len_q;
  assign INSTR_PC    = ipc_q;

endmodule
